// File: rtl/execute_memory_pipeline_reg.sv
// EX->MEM pipeline register for the 5-stage RV32 core: valid/ready handshake,
// synchronous flush, optional two-entry skid buffer and a saturating back-pressure counter.
module execute_memory_pipeline_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int SKID       = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  flush_i,
    input  logic                  RegWrite_i,
    input  logic [1:0]            ResultsSrc_i,
    input  logic                  MemWrite_i,
    input  logic [DATA_WIDTH-1:0] ALUResult_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    input  logic [ADDR_WIDTH-1:0] Rd_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  RegWrite_o,
    output logic [1:0]            ResultsSrc_o,
    output logic                  MemWrite_o,
    output logic [DATA_WIDTH-1:0] ALUResult_o,
    output logic [DATA_WIDTH-1:0] WriteData_o,
    output logic [ADDR_WIDTH-1:0] Rd_o,
    output logic [DATA_WIDTH-1:0] PCPlus4_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);
    localparam int PW = 4 + 3*DATA_WIDTH + ADDR_WIDTH;

    logic [PW-1:0]        beat_in;
    logic [PW-1:0]        main_q, main_d;
    logic                 main_vld;
    logic                 ready;
    logic                 in_fire, out_fire;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    logic                  head_rw, head_mw;
    logic [1:0]            head_rs;
    logic [DATA_WIDTH-1:0] head_alu, head_wd, head_pc;
    logic [ADDR_WIDTH-1:0] head_rd;

    assign beat_in  = {RegWrite_i, ResultsSrc_i, MemWrite_i, ALUResult_i,
                       WriteData_i, Rd_i, PCPlus4_i};
    assign in_fire  = valid_i & ready;
    assign out_fire = main_vld & ready_i;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
            state_t        state_q, state_d;
            logic [PW-1:0] skid_q, skid_d;
            logic          ready_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= EMPTY;
                    ready_q <= 1'b1;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != TWO);
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            // Flush wins over every handshake; the flushed beat is accepted but never stored.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush_i) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_d = ONE;
                                main_d  = beat_in;
                            end
                        end
                        ONE: begin
                            if (in_fire && out_fire) begin
                                main_d = beat_in;
                            end else if (in_fire) begin
                                state_d = TWO;
                                skid_d  = beat_in;
                            end else if (out_fire) begin
                                state_d = EMPTY;
                            end
                        end
                        TWO: begin
                            if (out_fire) begin
                                state_d = ONE;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end

            assign main_vld = (state_q != EMPTY);
            assign ready    = ready_q;

            a_two_not_ready: assert property (@(posedge clk) disable iff (rst)
                (state_q == TWO) |-> !ready_o);
        end else begin : g_single
            logic vld_q, vld_d;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    main_q <= '0;
                end else begin
                    vld_q  <= vld_d;
                    main_q <= main_d;
                end
            end

            always_comb begin
                vld_d  = vld_q;
                main_d = main_q;
                if (flush_i) begin
                    vld_d = 1'b0;
                end else if (in_fire) begin
                    vld_d  = 1'b1;
                    main_d = beat_in;
                end else if (out_fire) begin
                    vld_d = 1'b0;
                end
            end

            assign main_vld = vld_q;
            assign ready    = ready_i | ~vld_q;
        end
    endgenerate

    always_comb begin
        stall_d = stall_q;
        if (main_vld && !ready_i && !flush_i && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign {head_rw, head_rs, head_mw, head_alu, head_wd, head_rd, head_pc} = main_q;

    // Write enables are qualified so a bubble can never commit to the RF or memory.
    assign ready_o      = ready;
    assign valid_o      = main_vld;
    assign RegWrite_o   = head_rw & main_vld;
    assign MemWrite_o   = head_mw & main_vld;
    assign ResultsSrc_o = head_rs;
    assign ALUResult_o  = head_alu;
    assign WriteData_o  = head_wd;
    assign Rd_o         = head_rd;
    assign PCPlus4_o    = head_pc;
    assign stall_cnt_o  = stall_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(main_q)));
endmodule

// File: tb/tb_execute_memory_pipeline_reg.sv
// Directed bench: SKID=1/CNT_WIDTH=4 instance (a) and SKID=0/CNT_WIDTH=16 instance (b) on shared inputs.
module tb_execute_memory_pipeline_reg;
    logic        clk = 1'b0;
    logic        rst, valid_i, flush_i, rw_i, mw_i, ready_i;
    logic [1:0]  rs_i;
    logic [31:0] alu_i, wd_i, pc_i;
    logic [4:0]  rd_i;

    logic        a_ready, a_valid, a_rw, a_mw;
    logic [1:0]  a_rs;
    logic [31:0] a_alu, a_wd, a_pc;
    logic [4:0]  a_rd;
    logic [3:0]  a_stall;

    logic        b_ready, b_valid, b_rw, b_mw;
    logic [1:0]  b_rs;
    logic [31:0] b_alu, b_wd, b_pc;
    logic [4:0]  b_rd;
    logic [15:0] b_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execute_memory_pipeline_reg #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SKID(1), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(a_ready), .flush_i(flush_i),
        .RegWrite_i(rw_i), .ResultsSrc_i(rs_i), .MemWrite_i(mw_i), .ALUResult_i(alu_i),
        .WriteData_i(wd_i), .Rd_i(rd_i), .PCPlus4_i(pc_i), .valid_o(a_valid), .ready_i(ready_i),
        .RegWrite_o(a_rw), .ResultsSrc_o(a_rs), .MemWrite_o(a_mw), .ALUResult_o(a_alu),
        .WriteData_o(a_wd), .Rd_o(a_rd), .PCPlus4_o(a_pc), .stall_cnt_o(a_stall));

    execute_memory_pipeline_reg #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SKID(0), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(b_ready), .flush_i(flush_i),
        .RegWrite_i(rw_i), .ResultsSrc_i(rs_i), .MemWrite_i(mw_i), .ALUResult_i(alu_i),
        .WriteData_i(wd_i), .Rd_i(rd_i), .PCPlus4_i(pc_i), .valid_o(b_valid), .ready_i(ready_i),
        .RegWrite_o(b_rw), .ResultsSrc_o(b_rs), .MemWrite_o(b_mw), .ALUResult_o(b_alu),
        .WriteData_o(b_wd), .Rd_o(b_rd), .PCPlus4_o(b_pc), .stall_cnt_o(b_stall));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic mw,
                         input logic [31:0] alu, input logic [4:0] rd);
        valid_i = v;
        rw_i    = rw;
        mw_i    = mw;
        rs_i    = 2'b01;
        alu_i   = alu;
        wd_i    = alu ^ 32'hFFFF_0000;
        rd_i    = rd;
        pc_i    = 32'h1000 + alu;
    endtask

    task automatic stream();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            ready_i = 1'b1;
            flush_i = 1'b0;
            if (i < 8) drive(1'b1, 1'b1, 1'b0, 32'h10 + i, 5'(i));
            else       drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            if (i > 0) begin
                chk("stream_a_valid", 32'(a_valid), 32'd1);
                chk("stream_a_alu",   a_alu, 32'h10 + i - 1);
                chk("stream_a_pc",    a_pc,  32'h1010 + i - 1);
                chk("stream_a_ready", 32'(a_ready), 32'd1);
                chk("stream_b_valid", 32'(b_valid), 32'd1);
                chk("stream_b_alu",   b_alu, 32'h10 + i - 1);
                chk("stream_b_wd",    b_wd,  (32'h10 + i - 1) ^ 32'hFFFF_0000);
                chk("stream_b_ready", 32'(b_ready), 32'd1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        #12;
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_a_alu",   a_alu, 32'd0);
        chk("rst_a_stall", 32'(a_stall), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_b_pc",    b_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: streaming at full rate
        stream();
        chk("stream_a_stall", 32'(a_stall), 32'd0);
        chk("stream_b_stall", 32'(b_stall), 32'd0);

        // Test 2: back-pressure into the skid entry
        @(negedge clk); ready_i = 1'b0; drive(1'b1, 1'b0, 1'b0, 32'hA0, 5'd1); #1;
        chk("bp_ready_empty", 32'(a_ready), 32'd1);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'hB0, 5'd2); #1;
        chk("bp_valid_A", 32'(a_valid), 32'd1);
        chk("bp_alu_A",   a_alu, 32'hA0);
        chk("bp_ready_one", 32'(a_ready), 32'd1);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'hC0, 5'd3); #1;
        chk("bp_ready_two", 32'(a_ready), 32'd0);
        chk("bp_alu_held",  a_alu, 32'hA0);
        @(negedge clk); #1;
        chk("bp_stall_2", 32'(a_stall), 32'd2);
        chk("bp_ready_two_c", 32'(a_ready), 32'd0);
        @(negedge clk); #1;
        chk("bp_stall_3", 32'(a_stall), 32'd3);
        ready_i = 1'b1;
        @(negedge clk); #1;
        chk("bp_alu_B",   a_alu, 32'hB0);
        chk("bp_valid_B", 32'(a_valid), 32'd1);
        chk("bp_ready_B", 32'(a_ready), 32'd1);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0); #1;
        chk("bp_alu_C",   a_alu, 32'hC0);
        chk("bp_rd_C",    32'(a_rd), 32'd3);
        @(negedge clk); #1;
        chk("bp_drained", 32'(a_valid), 32'd0);
        chk("bp_stall_final", 32'(a_stall), 32'd3);

        // Test 3: flush while full
        @(negedge clk); ready_i = 1'b0; drive(1'b1, 1'b0, 1'b1, 32'h30, 5'd4);
        @(negedge clk); drive(1'b1, 1'b0, 1'b1, 32'h31, 5'd4);
        @(negedge clk); #1;
        chk("fl_ready_two", 32'(a_ready), 32'd0);
        chk("fl_mw_valid",  32'(a_mw), 32'd1);
        flush_i = 1'b1; drive(1'b1, 1'b0, 1'b1, 32'hDD, 5'd6);
        @(negedge clk); flush_i = 1'b0; ready_i = 1'b1; drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0); #1;
        chk("fl_valid",  32'(a_valid), 32'd0);
        chk("fl_mw",     32'(a_mw), 32'd0);
        chk("fl_ready",  32'(a_ready), 32'd1);
        chk("fl_stall_kept", 32'(a_stall), 32'd4);
        chk("fl_b_valid", 32'(b_valid), 32'd0);
        @(negedge clk); #1;
        chk("fl_no_D_valid", 32'(a_valid), 32'd0);
        chk("fl_no_D_alu",   a_alu, 32'h30);

        // Test 4: write-enable gating on a bubble
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 32'h40, 5'd5);
        @(negedge clk); #1;
        chk("gt_a_rw_1", 32'(a_rw), 32'd1);
        chk("gt_a_rd_1", 32'(a_rd), 32'd5);
        chk("gt_b_rw_1", 32'(b_rw), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
        @(negedge clk); #1;
        chk("gt_a_rw_0", 32'(a_rw), 32'd0);
        chk("gt_a_rd_5", 32'(a_rd), 32'd5);
        chk("gt_b_rw_0", 32'(b_rw), 32'd0);
        chk("gt_b_rd_5", 32'(b_rd), 32'd5);

        // Test 5: 4-bit stall counter saturation
        @(negedge clk); ready_i = 1'b0; drive(1'b1, 1'b0, 1'b0, 32'h50, 5'd7);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
            #1;
            if (k == 6) chk("sat_mid", 32'(a_stall), 32'd9);
        end
        chk("sat_15",    32'(a_stall), 32'd15);
        chk("sat_valid", 32'(a_valid), 32'd1);
        chk("sat_alu",   a_alu, 32'h50);
        repeat (3) @(negedge clk);
        #1;
        chk("sat_stays", 32'(a_stall), 32'd15);

        // Test 6: asynchronous reset between edges in the full state
        drive(1'b1, 1'b1, 1'b1, 32'h60, 5'd9);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0); #1;
        chk("ar_ready_two", 32'(a_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_a_valid", 32'(a_valid), 32'd0);
        chk("ar_a_alu",   a_alu, 32'd0);
        chk("ar_a_rd",    32'(a_rd), 32'd0);
        chk("ar_a_pc",    a_pc, 32'd0);
        chk("ar_a_stall", 32'(a_stall), 32'd0);
        chk("ar_b_alu",   b_alu, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("ar_a_ready", 32'(a_ready), 32'd1);
        chk("ar_b_ready", 32'(b_ready), 32'd1);
        stream();
        chk("ar_b_stall", 32'(b_stall), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
